// File: rtl/radon_pkg.sv
// Shared types and default widths for the radon ray accumulator.
package radon_pkg;

   localparam int PIX_W = 8;
   localparam int BIN_W = 6;
   localparam int ACC_W = 20;
   localparam int CNT_W = 16;

   localparam int NBINS = 2 ** BIN_W;
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN
   } radon_state_e;

endpackage

// File: rtl/radon_ray_accumulator_if.sv
// Pixel-in / bin-sum-out streams of the radon ray accumulator.
// The slave modport is the accumulator's view; master is the surrounding fabric.
interface radon_ray_accumulator_if #(
   parameter int PIX_W = radon_pkg::PIX_W,
   parameter int BIN_W = radon_pkg::BIN_W,
   parameter int ACC_W = radon_pkg::ACC_W
) ();

   logic             s_pix_valid;
   logic             s_pix_ready;
   logic [PIX_W-1:0] s_pix_data;
   logic [BIN_W-1:0] s_pix_bin;
   logic             s_pix_last;

   logic             m_sum_valid;
   logic             m_sum_ready;
   logic [ACC_W-1:0] m_sum_data;
   logic [BIN_W-1:0] m_sum_bin;
   logic             m_sum_last;

   modport master (
      output s_pix_valid, s_pix_data, s_pix_bin, s_pix_last, m_sum_ready,
      input  s_pix_ready, m_sum_valid, m_sum_data, m_sum_bin, m_sum_last
   );

   modport slave (
      input  s_pix_valid, s_pix_data, s_pix_bin, s_pix_last, m_sum_ready,
      output s_pix_ready, m_sum_valid, m_sum_data, m_sum_bin, m_sum_last
   );

endinterface

// File: rtl/radon_bin_bank.sv
// Register array of per-bin sums: synchronous clear, one add port, one combinational read port.
// RADON_ACC_SATURATE_EN selects clamping adds with an overflow pulse; otherwise adds wrap.
module radon_bin_bank #(
   parameter int PIX_W = radon_pkg::PIX_W,
   parameter int BIN_W = radon_pkg::BIN_W,
   parameter int ACC_W = radon_pkg::ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             add_en,
   input  logic [BIN_W-1:0] add_bin,
   input  logic [PIX_W-1:0] add_val,
   output logic             add_ovf,
   input  logic [BIN_W-1:0] rd_bin,
   output logic [ACC_W-1:0] rd_data
);
   import radon_pkg::*;

   localparam int NUM_BINS = 2 ** BIN_W;

   logic [ACC_W-1:0] acc_q [NUM_BINS];
   logic [ACC_W-1:0] add_result;

`ifdef RADON_ACC_SATURATE_EN
   // One extra bit catches the carry; any carry clamps the bin to all-ones.
   logic [ACC_W:0] sum_wide;

   assign sum_wide   = {1'b0, acc_q[add_bin]} + (ACC_W+1)'(add_val);
   assign add_result = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
   assign add_ovf    = add_en & sum_wide[ACC_W];
`else
   assign add_result = acc_q[add_bin] + ACC_W'(add_val);
   assign add_ovf    = 1'b0;
`endif

   assign rd_data = acc_q[rd_bin];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            acc_q[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            acc_q[i] <= '0;
         end
      end else if (add_en) begin
         acc_q[add_bin] <= add_result;
      end
   end

endmodule

// File: rtl/radon_ray_accumulator.sv
// Per-angle Radon projection accumulator: bins a tagged pixel stream, then drains all bin sums in order.
// Optional RADON_ACC_SATURATE_EN makes bin adds saturate and report overflow.
module radon_ray_accumulator #(
   parameter int PIX_W = radon_pkg::PIX_W,
   parameter int BIN_W = radon_pkg::BIN_W,
   parameter int ACC_W = radon_pkg::ACC_W,
   parameter int CNT_W = radon_pkg::CNT_W
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [CNT_W-1:0] pix_count,
   radon_ray_accumulator_if.slave bus
);
   import radon_pkg::*;

   radon_state_e     state_q;
   radon_state_e     state_d;
   logic [BIN_W-1:0] drain_bin_q;
   logic [CNT_W-1:0] pix_count_q;
   logic             done_q;
   logic             overflow_q;

   logic             start_acc;
   logic             pix_hs;
   logic             sum_hs;
   logic             sum_final;
   logic             add_ovf;
   logic [ACC_W-1:0] rd_data;

   // A start only counts from IDLE; mid-frame pulses from the register bank are dropped.
   assign start_acc = start && (state_q == IDLE);
   assign pix_hs    = bus.s_pix_valid && (state_q == ACCUM);
   assign sum_hs    = bus.m_sum_ready && (state_q == DRAIN);
   assign sum_final = sum_hs && (&drain_bin_q);

   radon_bin_bank #(
      .PIX_W (PIX_W),
      .BIN_W (BIN_W),
      .ACC_W (ACC_W)
   ) u_bank (
      .clk     (ACLK),
      .rst     (ARESET),
      .clear   (start_acc),
      .add_en  (pix_hs),
      .add_bin (bus.s_pix_bin),
      .add_val (bus.s_pix_data),
      .add_ovf (add_ovf),
      .rd_bin  (drain_bin_q),
      .rd_data (rd_data)
   );

   // Next-state and stream handshake outputs, all decoded from the registered state.
   always_comb begin
      state_d         = state_q;
      bus.s_pix_ready = 1'b0;
      bus.m_sum_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            bus.s_pix_ready = 1'b1;
            if (bus.s_pix_valid && bus.s_pix_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            bus.m_sum_valid = 1'b1;
            if (sum_final) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain pointer wraps back to zero after the last bin, ready for the next frame.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         drain_bin_q <= '0;
      end else if (start_acc) begin
         drain_bin_q <= '0;
      end else if (sum_hs) begin
         drain_bin_q <= drain_bin_q + BIN_W'(1);
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         pix_count_q <= '0;
      end else if (start_acc) begin
         pix_count_q <= '0;
      end else if (pix_hs && (pix_count_q != {CNT_W{1'b1}})) begin
         pix_count_q <= pix_count_q + CNT_W'(1);
      end
   end

   // Sticky status bits for the register bank, both cleared by an accepted start.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (start_acc) begin
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (sum_final) begin
            done_q <= 1'b1;
         end
         if (add_ovf) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Output data comes straight from the bank at the registered drain pointer;
   // nothing in DRAIN writes the bank, so it holds still while stalled.
   assign bus.m_sum_data = rd_data;
   assign bus.m_sum_bin  = drain_bin_q;
   assign bus.m_sum_last = (state_q == DRAIN) && (&drain_bin_q);

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign pix_count = pix_count_q;

endmodule

// File: tb/tb_radon_ray_accumulator.sv
// Self-checking bench for radon_ray_accumulator: scoreboard of expected bin sums checked on the output stream.
module tb_radon_ray_accumulator;
   import radon_pkg::*;

   localparam int SMALL_ACC_W = 10;

   logic ACLK   = 1'b0;
   logic ARESET = 1'b1;
   logic start  = 1'b0;
   logic start2 = 1'b0;

   logic             busy, done, overflow;
   logic [CNT_W-1:0] pix_count;
   logic             busy2, done2, overflow2;
   logic [CNT_W-1:0] pix_count2;

   radon_ray_accumulator_if #(.PIX_W(PIX_W), .BIN_W(BIN_W), .ACC_W(ACC_W)) bus ();
   radon_ray_accumulator_if #(.PIX_W(PIX_W), .BIN_W(BIN_W), .ACC_W(SMALL_ACC_W)) bus2 ();

   radon_ray_accumulator #(
      .PIX_W(PIX_W), .BIN_W(BIN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .busy(busy), .done(done),
      .overflow(overflow), .pix_count(pix_count), .bus(bus.slave)
   );

   radon_ray_accumulator #(
      .PIX_W(PIX_W), .BIN_W(BIN_W), .ACC_W(SMALL_ACC_W), .CNT_W(CNT_W)
   ) dut_small (
      .ACLK(ACLK), .ARESET(ARESET), .start(start2), .busy(busy2), .done(done2),
      .overflow(overflow2), .pix_count(pix_count2), .bus(bus2.slave)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [BIN_W-1:0] bin;
      logic [ACC_W-1:0] data;
      logic             last;
   } sum_t;

   sum_t sb[$];
   int   model [NBINS];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pops   = 0;

   // Output monitor: every valid beat must equal the scoreboard head; a handshake pops it.
   task automatic monitor();
      forever begin
         @(negedge ACLK);
         if (!ARESET && bus.m_sum_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_output: got bin %0d data %0d, expected no output", bus.m_sum_bin, bus.m_sum_data);
            end else begin
               if (bus.m_sum_bin !== sb[0].bin || bus.m_sum_data !== sb[0].data || bus.m_sum_last !== sb[0].last) begin
                  n_fail++;
                  $display("[TB] FAIL sum_out: got bin %0d data %0d last %b, expected bin %0d data %0d last %b",
                           bus.m_sum_bin, bus.m_sum_data, bus.m_sum_last, sb[0].bin, sb[0].data, sb[0].last);
               end
               if (bus.m_sum_ready) begin
                  if (sb[0].last) begin
                     n_checks++;
                     if (busy !== 1'b1 || done !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL flags_before_final: got busy %b done %b, expected busy 1 done 0", busy, done);
                     end
                  end
                  void'(sb.pop_front());
                  n_pops++;
               end
            end
         end
      end
   endtask

   task automatic push_expected();
      for (int b = 0; b < NBINS; b++) begin
         sb.push_back('{bin: BIN_W'(b), data: ACC_W'(model[b]), last: (b == NBINS-1)});
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      for (int b = 0; b < NBINS; b++) model[b] = 0;
   endtask

   task automatic send_pix(input logic [BIN_W-1:0] bin, input logic [PIX_W-1:0] val, input logic last);
      int w = 0;
      bus.s_pix_valid = 1'b1;
      bus.s_pix_data  = val;
      bus.s_pix_bin   = bin;
      bus.s_pix_last  = last;
      @(negedge ACLK);
      while (bus.s_pix_ready !== 1'b1 && w < 50) begin
         @(negedge ACLK);
         w++;
      end
      if (w >= 50) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL pix_ready_timeout: got ready %b, expected 1 within 50 cycles", bus.s_pix_ready);
      end else begin
         model[bin] = (model[bin] + int'(val)) & ((1 << ACC_W) - 1);
      end
      @(posedge ACLK); #1;
      bus.s_pix_valid = 1'b0;
      bus.s_pix_last  = 1'b0;
      if (last) push_expected();
   endtask

   // Drain with ready held high (mode 0) or cycling 1-0-0-1 (mode 1); start pulsed at cycle start_at.
   task automatic drain(input int mode, input int start_at);
      int         cyc = 0;
      logic [3:0] pat = 4'b1001;
      while (sb.size() != 0 && cyc < 1000) begin
         bus.m_sum_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
         start = (cyc == start_at);
         @(posedge ACLK); #1;
         cyc++;
      end
      bus.m_sum_ready = 1'b0;
      start = 1'b0;
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: got %0d sums pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || pix_count !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got busy %b done %b ovf %b count %0d, expected all 0", busy, done, overflow, pix_count);
      end
      n_checks++;
      if (bus.s_pix_ready !== 1'b0 || bus.m_sum_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_handshake: got ready %b valid %b, expected 0 0", bus.s_pix_ready, bus.m_sum_valid);
      end
      n_checks++;
      if (bus.m_sum_data !== '0 || bus.m_sum_bin !== '0 || bus.m_sum_last !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_sum_out: got data %0d bin %0d last %b, expected 0 0 0", bus.m_sum_data, bus.m_sum_bin, bus.m_sum_last);
      end
   endtask

   task automatic test_basic();
      pulse_start();
      n_checks++;
      if (busy !== 1'b1 || bus.s_pix_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL start_response: got busy %b ready %b, expected 1 1", busy, bus.s_pix_ready);
      end
      for (int i = 0; i < 4; i++) send_pix(6'd3, 8'd10, (i == 3));
      n_checks++;
      if (bus.s_pix_ready !== 1'b0 || bus.m_sum_valid !== 1'b1 || bus.m_sum_bin !== '0) begin
         n_fail++;
         $display("[TB] FAIL enter_drain: got ready %b valid %b bin %0d, expected 0 1 0", bus.s_pix_ready, bus.m_sum_valid, bus.m_sum_bin);
      end
      n_checks++;
      if (pix_count !== 16'd4) begin
         n_fail++;
         $display("[TB] FAIL basic_count: got %0d, expected 4", pix_count);
      end
      drain(0, -1);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_done: got done %b busy %b ovf %b, expected 1 0 0", done, busy, overflow);
      end
   endtask

   task automatic test_full_frame();
      int pops_before;
      pulse_start();
      for (int i = 0; i < 4096; i++) send_pix(BIN_W'(i % NBINS), 8'd1, (i == 4095));
      n_checks++;
      if (pix_count !== 16'd4096) begin
         n_fail++;
         $display("[TB] FAIL full_count: got %0d, expected 4096", pix_count);
      end
      pops_before = n_pops;
      drain(0, -1);
      n_checks++;
      if (n_pops - pops_before != NBINS || done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL full_outputs: got %0d outputs done %b, expected 64 1", n_pops - pops_before, done);
      end
   endtask

   task automatic test_stall();
      pulse_start();
      for (int i = 0; i < 24; i++) begin
         send_pix(BIN_W'($urandom_range(0, NBINS-1)), PIX_W'($urandom_range(0, 255)), (i == 23));
      end
      drain(1, -1);
      n_checks++;
      if (pix_count !== 16'd24 || done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL stall_end: got count %0d done %b, expected 24 1", pix_count, done);
      end
   endtask

   task automatic test_start_ignored();
      pulse_start();
      for (int i = 0; i < 5; i++) send_pix(BIN_W'((i * 7) % NBINS), PIX_W'(i * 13 + 1), 1'b0);
      start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || bus.s_pix_ready !== 1'b1 || pix_count !== 16'd5) begin
         n_fail++;
         $display("[TB] FAIL start_in_accum: got busy %b ready %b count %0d, expected 1 1 5", busy, bus.s_pix_ready, pix_count);
      end
      start = 1'b1;
      send_pix(6'd9, 8'd200, 1'b0);
      start = 1'b0;
      for (int i = 6; i < 10; i++) send_pix(BIN_W'((i * 7) % NBINS), PIX_W'(i * 13 + 1), (i == 9));
      drain(0, 10);
      n_checks++;
      if (pix_count !== 16'd10 || done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL start_ignored_end: got count %0d done %b busy %b, expected 10 1 0", pix_count, done, busy);
      end
   endtask

   task automatic test_saturation();
      int                     w = 0;
      logic [SMALL_ACC_W-1:0] exp_sum;
      logic                   exp_ovf;
`ifdef RADON_ACC_SATURATE_EN
      exp_sum = 10'd1023;
      exp_ovf = 1'b1;
`else
      exp_sum = 10'd251;
      exp_ovf = 1'b0;
`endif
      start2 = 1'b1;
      @(posedge ACLK); #1;
      start2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus2.s_pix_valid = 1'b1;
         bus2.s_pix_data  = 8'd255;
         bus2.s_pix_bin   = 6'd0;
         bus2.s_pix_last  = (i == 4);
         @(negedge ACLK);
         n_checks++;
         if (bus2.s_pix_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sat_ready: got %b, expected 1", bus2.s_pix_ready);
         end
         @(posedge ACLK); #1;
      end
      bus2.s_pix_valid = 1'b0;
      bus2.s_pix_last  = 1'b0;
      n_checks++;
      if (bus2.m_sum_valid !== 1'b1 || bus2.m_sum_bin !== '0 || bus2.m_sum_data !== exp_sum) begin
         n_fail++;
         $display("[TB] FAIL sat_bin0: got valid %b bin %0d data %0d, expected 1 0 %0d", bus2.m_sum_valid, bus2.m_sum_bin, bus2.m_sum_data, exp_sum);
      end
      n_checks++;
      if (overflow2 !== exp_ovf) begin
         n_fail++;
         $display("[TB] FAIL sat_overflow: got %b, expected %b", overflow2, exp_ovf);
      end
      bus2.m_sum_ready = 1'b1;
      while (done2 !== 1'b1 && w < 200) begin
         @(posedge ACLK); #1;
         w++;
      end
      bus2.m_sum_ready = 1'b0;
      n_checks++;
      if (done2 !== 1'b1 || pix_count2 !== 16'd5) begin
         n_fail++;
         $display("[TB] FAIL sat_done: got done %b count %0d, expected 1 5", done2, pix_count2);
      end
   endtask

   task automatic test_reset_midframe();
      pulse_start();
      for (int i = 0; i < 100; i++) send_pix(BIN_W'(i % NBINS), PIX_W'(i), 1'b0);
      ARESET = 1'b1;
      #2;
      n_checks++;
      if (busy !== 1'b0 || pix_count !== '0 || bus.s_pix_ready !== 1'b0 || bus.m_sum_valid !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midframe_reset: got busy %b count %0d ready %b valid %b done %b, expected 0 0 0 0 0",
                  busy, pix_count, bus.s_pix_ready, bus.m_sum_valid, done);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      pulse_start();
      send_pix(6'd5, 8'd7, 1'b0);
      send_pix(6'd5, 8'd9, 1'b1);
      n_checks++;
      if (pix_count !== 16'd2) begin
         n_fail++;
         $display("[TB] FAIL after_reset_count: got %0d, expected 2", pix_count);
      end
      drain(0, -1);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL after_reset_done: got %b, expected 1", done);
      end
   endtask

   initial begin
      bus.s_pix_valid  = 1'b0;
      bus.s_pix_data   = '0;
      bus.s_pix_bin    = '0;
      bus.s_pix_last   = 1'b0;
      bus.m_sum_ready  = 1'b0;
      bus2.s_pix_valid = 1'b0;
      bus2.s_pix_data  = '0;
      bus2.s_pix_bin   = '0;
      bus2.s_pix_last  = 1'b0;
      bus2.m_sum_ready = 1'b0;
      for (int b = 0; b < NBINS; b++) model[b] = 0;

      fork
         monitor();
         begin
            #2000000;
            $display("[TB] FAIL watchdog: got simulation still running, expected completion");
            $fatal(1, "[TB] watchdog expired");
         end
      join_none

      repeat (3) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;

      test_reset();
      test_basic();
      test_full_frame();
      test_stall();
      test_start_ignored();
      test_saturation();
      test_reset_midframe();

      repeat (3) @(posedge ACLK);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/radon_ray_accumulator.md
# radon_ray_accumulator

Streaming Radon-projection accumulator sitting directly downstream of the AXI4-Lite register slave of the radon IP. The register bank drives `start` and reads back `busy`/`done`/`pix_count`/`overflow`. For one projection angle the block consumes a pixel stream tagged with precomputed bin indices, sums pixel values per bin, then drains the NBINS sums on an output stream.

## Interface
- `PIX_W`, 8, pixel value width
- `BIN_W`, 6, bin index width; NBINS = 2**BIN_W
- `ACC_W`, 20, accumulator width per bin
- `CNT_W`, 16, pixel counter width
- `ACLK`  in  1  clock
- `ARESET`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse from the register bank; begins a frame
- `busy`  out  1  high from the cycle after an accepted start until drain completes
- `done`  out  1  sticky; set on drain completion, cleared by the next accepted start
- `overflow`  out  1  sticky saturation flag, cleared by accepted start
- `pix_count`  out  CNT_W  pixels accepted in the current/last frame
- `s_pix_valid` / `s_pix_ready`  in/out  1  input handshake
- `s_pix_data`  in  PIX_W  unsigned pixel value
- `s_pix_bin`  in  BIN_W  target bin
- `s_pix_last`  in  1  final pixel of the frame
- `m_sum_valid` / `m_sum_ready`  out/in  1  output handshake
- `m_sum_data`  out  ACC_W  bin sum
- `m_sum_bin`  out  BIN_W  bin index of `m_sum_data`
- `m_sum_last`  out  1  high with bin NBINS-1

## Operation
- FSM: IDLE, ACCUM, DRAIN.
- IDLE: `s_pix_ready`=0 and `m_sum_valid`=0. `start` moves to ACCUM, clears all bins, `pix_count`, `done` and `overflow` in the same edge.
- `start` outside IDLE is ignored. No effect on state, bins or flags.
- ACCUM: `s_pix_ready`=1. Each handshake adds `s_pix_data` (zero-extended) to `acc[s_pix_bin]` and increments `pix_count`. `pix_count` saturates at 2**CNT_W-1.
- Handshake with `s_pix_last`=1 is accumulated, then moves to DRAIN.
- Back-to-back pixels to the same bin must all be counted; the bank is a register array, so no RMW hazard exists.
- DRAIN: outputs bin 0..NBINS-1 in order, one per handshake.
- Handshake on bin NBINS-1 (`m_sum_last`=1) moves to IDLE and sets `done`.
- Bins are not cleared by drain, only by start.
- Reset mid-frame: everything returns to reset values; the partial frame is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `overflow`=0, `pix_count`=0, `s_pix_ready`=0, `m_sum_valid`=0, `m_sum_data`=0, `m_sum_bin`=0, `m_sum_last`=0, all bins 0.
- `start` sampled at edge k: `busy`=1 and `s_pix_ready`=1 from cycle k+1.
- A pixel accepted at edge n is visible in its bin at edge n+1.
- Last pixel accepted at edge n: `s_pix_ready`=0 and `m_sum_valid`=1 with bin 0 from cycle n+1.
- Output registered; data/bin/last are held stable while `m_sum_valid`=1 and `m_sum_ready`=0.
- With `m_sum_ready` held high, one bin per cycle; drain takes NBINS cycles.
- `busy` falls and `done` rises together, the cycle after the final output handshake.

## Configuration
- `RADON_ACC_SATURATE_EN` defined: an add whose result exceeds 2**ACC_W-1 clamps to 2**ACC_W-1 and sets `overflow`.
- `RADON_ACC_SATURATE_EN` undefined: adds wrap modulo 2**ACC_W and `overflow` is tied to 0.

## Structure
- Package `radon_pkg` holds:
  - the state enum (IDLE/ACCUM/DRAIN)
  - default width constants PIX_W/BIN_W/ACC_W/CNT_W
  - NBINS and ACC_MAX localparams
- Sub-module `radon_bin_bank` is the register array. It has:
  - a synchronous clear
  - one add port with the saturate/wrap logic
  - one combinational read port indexed by the drain counter
- FSM, counters and output register stay in the top.

## Test plan
- Reset, then start; stream 4 pixels (bin 3, value 10) ×4 with last on the 4th, ready held high -> drain shows bin 3 = 40, all other bins 0, `pix_count`=4, `done`=1 one cycle after bin 63 handshake.
- Full 64×64 frame, pixel value 1, bin = pixel index mod 64 -> every bin = 64, `pix_count`=4096, 64 outputs, `m_sum_last` only on bin 63.
- `m_sum_ready` toggled 1-0-0-1 during drain -> no bin skipped or duplicated; data stable while stalled.
- With the macro defined, ACC_W=10, 5 pixels of 255 to bin 0 -> bin 0 = 1023 and `overflow`=1. Without the macro -> bin 0 = 1275 mod 1024 = 251, `overflow`=0.
- `start` pulsed during ACCUM and during DRAIN -> ignored; results match the undisturbed run.
- `ARESET` asserted mid-ACCUM after 100 pixels, then a new 2-pixel frame (bin 5, values 7 and 9) -> bin 5 = 16, all others 0, `pix_count`=2.
